// File: rtl/arb_req_gen_if.sv
// Request/grant bundle between channel sources, the round-robin arbiter and arb_req_gen.
// The slave side is arb_req_gen; the master side drives push/grant and observes the rest.
interface arb_req_gen_if #(
  parameter int N = 3
);
  localparam int CH_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    push;
  logic [N-1:0]    grant;
  logic [N-1:0]    full;
  logic [N-1:0]    req_vld;
  logic [N-1:0]    starve;
  logic            out_vld;
  logic [CH_W-1:0] out_ch;
  logic            err;

  modport master (
    output push, grant,
    input  full, req_vld, starve, out_vld, out_ch, err
  );

  modport slave (
    input  push, grant,
    output full, req_vld, starve, out_vld, out_ch, err
  );
endinterface

// File: rtl/arb_req_gen.sv
// Requester side of the round-robin arbiter: per-channel pending counters, retire reporting
// and starvation flags. Define ARB_REQ_CHK_EN to compile in the sticky grant protocol checker.
module arb_req_gen #(
  parameter int N          = 3,
  parameter int CNT_W      = 4,
  parameter int STARVE_LIM = 16
) (
  input  logic          clk,
  input  logic          rst,
  arb_req_gen_if.slave  bus
);
  localparam int CH_W   = (N > 1) ? $clog2(N) : 1;
  localparam int WAIT_W = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(STARVE_LIM);

  logic [CNT_W-1:0]  r_cnt      [N];
  logic [CNT_W-1:0]  w_cnt_nxt  [N];
  logic [WAIT_W-1:0] r_wait     [N];
  logic [WAIT_W-1:0] w_wait_nxt [N];
  logic [N-1:0]      r_starve;
  logic [N-1:0]      w_starve_nxt;
  logic [N-1:0]      w_req;
  logic [N-1:0]      w_full;
  logic [N-1:0]      w_acc;
  logic              r_out_vld;
  logic              w_out_vld_nxt;
  logic [CH_W-1:0]   r_out_ch;
  logic [CH_W-1:0]   w_out_ch_nxt;

  // Status is decoded purely from the counters, so no input reaches req_vld/full combinationally.
  always_comb begin
    w_req  = '0;
    w_full = '0;
    for (int i = 0; i < N; i++) begin
      w_req[i]  = (r_cnt[i] != '0);
      w_full[i] = (r_cnt[i] == CNT_MAX);
    end
  end

  assign w_acc = bus.grant & w_req;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      case ({bus.push[i], w_acc[i]})
        2'b10:   if (!w_full[i]) w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        2'b01:   w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
        default: w_cnt_nxt[i] = r_cnt[i];
      endcase
    end
  end

  // starve is one cycle behind the saturated wait count, but drops on the accepting edge.
  always_comb begin
    w_starve_nxt = '0;
    for (int i = 0; i < N; i++) begin
      w_wait_nxt[i] = r_wait[i];
      if (!w_req[i] || w_acc[i]) begin
        w_wait_nxt[i] = '0;
      end else if (r_wait[i] != WAIT_LIM) begin
        w_wait_nxt[i] = r_wait[i] + WAIT_W'(1);
      end
      w_starve_nxt[i] = (r_wait[i] == WAIT_LIM) && w_req[i] && !w_acc[i];
    end
  end

  // Scan from the top so the lowest accepted channel wins.
  always_comb begin
    w_out_vld_nxt = |w_acc;
    w_out_ch_nxt  = r_out_ch;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_acc[i]) w_out_ch_nxt = CH_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_cnt[i]  <= '0;
        r_wait[i] <= '0;
      end
      r_starve  <= '0;
      r_out_vld <= 1'b0;
      r_out_ch  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        r_cnt[i]  <= w_cnt_nxt[i];
        r_wait[i] <= w_wait_nxt[i];
      end
      r_starve  <= w_starve_nxt;
      r_out_vld <= w_out_vld_nxt;
      r_out_ch  <= w_out_ch_nxt;
    end
  end

  assign bus.req_vld = w_req;
  assign bus.full    = w_full;
  assign bus.starve  = r_starve;
  assign bus.out_vld = r_out_vld;
  assign bus.out_ch  = r_out_ch;

`ifdef ARB_REQ_CHK_EN
  logic r_err;
  logic w_multi;
  logic w_orphan;

  assign w_multi  = (bus.grant != '0) && ((bus.grant & (bus.grant - N'(1))) != '0);
  assign w_orphan = |(bus.grant & ~w_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err | w_multi | w_orphan;
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_arb_req_gen.sv
// Self-checking bench for arb_req_gen: directed scenarios with literal expectations, then
// randomized push/grant traffic compared every cycle against a counting model.
module tb_arb_req_gen;
  localparam int N    = 3;
  localparam int CNTW = 4;
  localparam int LIM  = 16;
  localparam int MAXC = 15;
`ifdef ARB_REQ_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arb_req_gen_if #(.N(N)) bus ();
  arb_req_gen #(.N(N), .CNT_W(CNTW), .STARVE_LIM(LIM)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Model: pending requests per channel, consecutive unserved waiting edges, retire/err state.
  int m_cnt [N];
  int m_run [N];
  bit m_out_vld;
  int m_out_ch;
  bit m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    logic [N-1:0] p;
    logic [N-1:0] g;
    logic [N-1:0] req;
    logic [N-1:0] acc;
    bit found;
    p = bus.push;
    g = bus.grant;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_cnt[i] = 0;
        m_run[i] = 0;
      end
      m_out_vld = 0;
      m_out_ch  = 0;
      m_err     = 0;
    end else begin
      for (int i = 0; i < N; i++) req[i] = (m_cnt[i] != 0);
      acc = g & req;
      if (CHK && (($countones(g) > 1) || ((g & ~req) != 0))) m_err = 1;
      m_out_vld = (acc != 0);
      found = 0;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && !found) begin
          m_out_ch = i;
          found = 1;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (p[i] && !acc[i] && m_cnt[i] < MAXC) m_cnt[i] = m_cnt[i] + 1;
        if (acc[i] && !p[i]) m_cnt[i] = m_cnt[i] - 1;
        if (req[i] && !acc[i]) m_run[i] = (m_run[i] < 1000) ? m_run[i] + 1 : m_run[i];
        else m_run[i] = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] e_req;
    logic [N-1:0] e_full;
    logic [N-1:0] e_starve;
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        e_req[i]    = (m_cnt[i] != 0);
        e_full[i]   = (m_cnt[i] == MAXC);
        e_starve[i] = (m_run[i] >= LIM + 1);
      end
      check("req_vld", 32'(bus.req_vld), 32'(e_req));
      check("full", 32'(bus.full), 32'(e_full));
      check("starve", 32'(bus.starve), 32'(e_starve));
      check("out_vld", 32'(bus.out_vld), 32'(m_out_vld));
      check("out_ch", 32'(bus.out_ch), 32'(m_out_ch));
      check("err", 32'(bus.err), 32'(m_err));
    end
  end

  task automatic drive(input logic [N-1:0] p, input logic [N-1:0] g);
    bus.push  = p;
    bus.grant = g;
    @(posedge clk);
    #1;
    bus.push  = '0;
    bus.grant = '0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bus.push  = '0;
    bus.grant = '0;

    // Reset then idle
    do_reset(3);
    chk_en = 1'b1;
    check("rst_req_vld", 32'(bus.req_vld), 32'd0);
    check("rst_out_vld", 32'(bus.out_vld), 32'd0);
    check("rst_out_ch", 32'(bus.out_ch), 32'd0);
    check("rst_starve", 32'(bus.starve), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    drive(3'b101, 3'b000);
    check("idle_req_vld", 32'(bus.req_vld), 32'b101);
    check("idle_full", 32'(bus.full), 32'd0);

    // Round-robin drain
    do_reset(1);
    drive(3'b111, 3'b000);
    drive(3'b000, 3'b001);
    check("rr0_vld", 32'(bus.out_vld), 32'd1);
    check("rr0_ch", 32'(bus.out_ch), 32'd0);
    drive(3'b000, 3'b010);
    check("rr1_vld", 32'(bus.out_vld), 32'd1);
    check("rr1_ch", 32'(bus.out_ch), 32'd1);
    drive(3'b000, 3'b100);
    check("rr2_vld", 32'(bus.out_vld), 32'd1);
    check("rr2_ch", 32'(bus.out_ch), 32'd2);
    check("rr_req_vld", 32'(bus.req_vld), 32'd0);

    // Saturation on ch0
    do_reset(1);
    for (int k = 1; k <= 16; k++) begin
      drive(3'b001, 3'b000);
      check("sat_full", 32'(bus.full[0]), 32'(k >= 15));
    end
    drive(3'b001, 3'b001);
    check("sat_pa_vld", 32'(bus.out_vld), 32'd1);
    check("sat_pa_full", 32'(bus.full[0]), 32'd1);
    for (int k = 1; k <= 15; k++) begin
      drive(3'b000, 3'b001);
      check("sat_drain_vld", 32'(bus.out_vld), 32'd1);
    end
    check("sat_req_vld", 32'(bus.req_vld[0]), 32'd0);
    drive(3'b000, 3'b001);
    check("sat_ign_vld", 32'(bus.out_vld), 32'd0);
    check("sat_ign_ch", 32'(bus.out_ch), 32'd0);

    // Simultaneous push and grant on ch1 with two pending
    do_reset(1);
    drive(3'b010, 3'b000);
    drive(3'b010, 3'b000);
    drive(3'b010, 3'b010);
    check("sim_vld", 32'(bus.out_vld), 32'd1);
    check("sim_ch", 32'(bus.out_ch), 32'd1);
    drive(3'b000, 3'b010);
    check("sim_req1", 32'(bus.req_vld[1]), 32'd1);
    drive(3'b000, 3'b010);
    check("sim_req2", 32'(bus.req_vld[1]), 32'd0);

    // Starvation on ch2
    do_reset(1);
    drive(3'b100, 3'b000);
    for (int k = 1; k <= 17; k++) begin
      drive(3'b000, 3'b000);
      check("stv_wait", 32'(bus.starve[2]), 32'(k >= 17));
    end
    drive(3'b000, 3'b100);
    check("stv_clear", 32'(bus.starve[2]), 32'd0);

    // Protocol checker
    do_reset(1);
    drive(3'b001, 3'b000);
    drive(3'b000, 3'b011);
    check("chk_multi", 32'(bus.err), 32'(CHK));
    repeat (3) drive(3'b000, 3'b000);
    check("chk_hold", 32'(bus.err), 32'(CHK));
    do_reset(1);
    check("chk_rst", 32'(bus.err), 32'd0);
    drive(3'b001, 3'b000);
    drive(3'b000, 3'b010);
    check("chk_orphan", 32'(bus.err), 32'(CHK));

    // Randomized traffic
    do_reset(1);
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] p;
      logic [N-1:0] g;
      int r;
      int k;
      p = '0;
      for (int i = 0; i < N; i++) if ($urandom_range(0, 3) == 0) p[i] = 1'b1;
      r = $urandom_range(0, 99);
      if (r < 15) begin
        g = N'($urandom_range(0, 7));
      end else if (r < 70) begin
        k = $urandom_range(0, N - 1);
        g = (m_cnt[k] != 0) ? N'(1 << k) : '0;
      end else begin
        g = '0;
      end
      rst = ($urandom_range(0, 199) == 0);
      drive(p, g);
      rst = 1'b0;
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
